cbus_axi_bridge: RTL and testbench
==================================

Name: cbus_axi_bridge

Overview:
- Downstream neighbour of the data cache. Converts one cache-bus (CBus) line transaction at a time into an AXI3 burst on the memory interface.
- Supported transactions: line refill (read) and victim writeback (write).
- Returns per-beat okay/last/rdata to the cache.
- Bursts are critical-word-first (WRAP), matching the cache's wrapping beat offset.

Parameters:
- AXI_ID, 0, constant ID driven on ARID/AWID/WID.
- DATA_WIDTH, 32, beat width; equals the CBus data width.
- MAX_ORDER, 4, largest supported log2(beats); MAX_ORDER=4 gives 16 beats, the AXI3 limit.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- cbus_req  in  cbus_req_t  valid, is_write, addr[31:0], order, wdata[31:0]
- cbus_resp  out  cbus_resp_t  okay, last, rdata[31:0]
- araddr/arlen/arsize/arburst/arid/arvalid  out  32/4/3/2/4/1  AXI read address
- arready  in  1
- rdata/rresp/rlast/rid/rvalid  in  32/2/1/4/1
- rready  out  1
- awaddr/awlen/awsize/awburst/awid/awvalid  out  32/4/3/2/4/1
- awready  in  1
- wdata/wstrb/wlast/wid/wvalid  out  32/4/1/4/1
- wready  in  1
- bresp/bid/bvalid  in  2/4/1
- bready  out  1

Behaviour:
- Reset (resetn=0 at clk edge):
  - state<=IDLE; arvalid, awvalid, wvalid, rready, bready all 0.
  - cbus_resp.okay/last = 0.
  - Reset mid-burst abandons the transaction; permitted only at system reset.
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE, on cbus_req.valid:
  - Latch addr, order, is_write.
  - Next state AR (read) or AW (write).
  - arvalid/awvalid rise the next cycle (1-cycle issue latency).
- Address channel fields:
  - len = (1<<order)-1; size = 3'b010; id = AXI_ID.
  - burst = WRAP when order>0, INCR when order==0.
  - addr passed through unaligned; WRAP handles the critical-word-first start.
- AR: hold arvalid until arready, then go to R.
- R:
  - rready=1.
  - cbus_resp.okay = rvalid; rdata passed through combinationally; cbus_resp.last = rvalid & rlast.
  - On rvalid & rlast, go to IDLE.
- AW: hold awvalid until awready, then go to W; the beat counter clears on entry.
- W:
  - wvalid=1; wdata = cbus_req.wdata; wstrb = 4'hF.
  - wlast = (count == len).
  - On a wready handshake: count++. For a non-final beat, okay=1 that cycle so the cache advances its wdata index.
  - Final beat: okay is NOT raised. Go to B.
- B:
  - bready=1.
  - On bvalid: okay=1 and last=1 in the same cycle, then go to IDLE.
  - For writes, last therefore marks full completion; the cache's final offset increment wraps it to the start offset.
- rresp/bresp errors are ignored and never reported.
- CBus contract:
  - Requester holds valid and addr stable from accept until last.
  - wdata changes only after an okay.
- The bridge ignores cbus_req.valid in the cycle last is asserted. A new request is taken from IDLE the following cycle, so back-to-back read→write costs 1 idle cycle.
- The bridge never asserts okay outside the R/W/B states; last is only ever asserted together with okay.
- order > MAX_ORDER is unsupported and not checked.

Decomposition:
- cbus_req_t/cbus_resp_t and cbus_order_t stay in the existing cache bus header.
- A shared axi_pkg holds:
  - AXI_BURST_FIXED/INCR/WRAP, AXI_SIZE_4B
  - axi_len_t (4 bits), axi_id_t
  - ar/aw/w/r/b channel struct typedefs
- Single flat module; no sub-module needed.
- The len/burst computation is a package function, axi_burst_of(order), shared with the future instruction-side bridge.

Test Plan:
- Read, order=2, addr=0x1000_0008, arready after 2 cycles:
  - arlen=3, arburst=WRAP, araddr=0x1000_0008.
  - 4 rvalid beats give okay on each; last only on the rlast beat; rdata matches each beat.
- Write, order=2, wready toggled 1/0/1/1/1, bvalid 3 cycles after the final beat:
  - wlast only on the 4th accepted beat; okay on 3 handshakes.
  - okay&last together only on the bvalid cycle.
- order=0 read:
  - arburst=INCR, arlen=0; a single beat gives okay&last.
- Back-to-back: read completes (last), write valid already high:
  - awvalid rises exactly 2 cycles after the last cycle (1 IDLE cycle, then AW); no double issue.
- Reset asserted during R after beat 1:
  - next cycle rready=0, okay=0, state IDLE; a fresh request is accepted normally after deassert.
- rvalid stalled mid-burst 5 cycles:
  - okay stays low throughout the stall; the beat count is still exactly 2^order okays.

Source files
------------

// File: rtl/cbus_axi_bridge_pkg.sv
// Shared types for the data-cache bus to AXI3 bridge: cache-bus request and
// response records, AXI3 channel records, and the order-to-burst mapping
// that the future instruction-side bridge will also use.
package cbus_axi_bridge_pkg;

    // Cache bus (CBus) widths and records
    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_DATA_W = 32;

    // log2 of the number of beats in a line transaction
    typedef logic [2:0] cbus_order_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        cbus_order_t            order;
        logic [CBUS_DATA_W-1:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic                   okay;
        logic                   last;
        logic [CBUS_DATA_W-1:0] rdata;
    } cbus_resp_t;

    // AXI3 encodings
    typedef logic [1:0] axi_burst_t;
    typedef logic [2:0] axi_size_t;
    typedef logic [3:0] axi_len_t;
    typedef logic [3:0] axi_id_t;
    typedef logic [1:0] axi_resp_t;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;
    localparam axi_size_t  AXI_SIZE_4B     = 3'b010;

    // Address channel record, shared by AR and AW
    typedef struct packed {
        logic [31:0] addr;
        axi_len_t    len;
        axi_size_t   size;
        axi_burst_t  burst;
        axi_id_t     id;
    } axi_ax_chan_t;

    typedef axi_ax_chan_t axi_ar_chan_t;
    typedef axi_ax_chan_t axi_aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        axi_id_t     id;
    } axi_w_chan_t;

    typedef struct packed {
        logic [31:0] data;
        axi_resp_t   resp;
        logic        last;
        axi_id_t     id;
    } axi_r_chan_t;

    typedef struct packed {
        axi_resp_t resp;
        axi_id_t   id;
    } axi_b_chan_t;

    // Burst shape derived from a line order
    typedef struct packed {
        axi_len_t   len;
        axi_burst_t burst;
    } axi_burst_info_t;

    // A single-beat line cannot wrap, so order 0 becomes a one-beat INCR.
    // Everything else wraps so the critical word returns first.
    function automatic axi_burst_info_t axi_burst_of(input cbus_order_t order);
        axi_burst_info_t info;
        logic [15:0]     beats;
        logic [15:0]     beats_m1;
        beats    = 16'd1 << order;
        beats_m1 = beats - 16'd1;
        info.len = beats_m1[3:0];
        if (order == 3'd0) begin
            info.burst = AXI_BURST_INCR;
        end else begin
            info.burst = AXI_BURST_WRAP;
        end
        return info;
    endfunction

    // Bridge controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } bridge_state_t;

endpackage

// File: rtl/cbus_axi_bridge.sv
// Data-cache bus to AXI3 bridge. Accepts one line transaction at a time
// (refill or victim writeback) and runs it as a single critical-word-first
// burst, returning per-beat okay/last/rdata to the cache.
module cbus_axi_bridge
    import cbus_axi_bridge_pkg::*;
#(
    parameter axi_id_t AXI_ID     = 4'd0,
    parameter int      DATA_WIDTH = 32,
    parameter int      MAX_ORDER  = 4
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  cbus_req_t               cbus_req,
    output cbus_resp_t              cbus_resp,

    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [3:0]              arid,
    output logic                    arvalid,
    input  logic                    arready,

    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic [3:0]              rid,
    input  logic                    rvalid,
    output logic                    rready,

    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [3:0]              awid,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic [3:0]              wid,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [1:0]              bresp,
    input  logic [3:0]              bid,
    input  logic                    bvalid,
    output logic                    bready
);

    bridge_state_t          state_r;
    bridge_state_t          state_next_s;
    axi_ax_chan_t           ax_r;
    axi_burst_info_t        burst_info_s;
    logic [MAX_ORDER-1:0]   count_r;
    logic                   final_beat_s;

    // Error responses and returned IDs are deliberately not reported to the cache.
    logic                   unused_resp_s;
    assign unused_resp_s = ^{rresp, rid, bresp, bid};

    assign burst_info_s = axi_burst_of(cbus_req.order);
    assign final_beat_s = (count_r == ax_r.len[MAX_ORDER-1:0]);

    // Address channels carry the request latched at accept; the unaligned
    // address goes out as-is so WRAP starts on the critical word.
    assign araddr  = ax_r.addr;
    assign arlen   = ax_r.len;
    assign arsize  = ax_r.size;
    assign arburst = ax_r.burst;
    assign arid    = ax_r.id;
    assign awaddr  = ax_r.addr;
    assign awlen   = ax_r.len;
    assign awsize  = ax_r.size;
    assign awburst = ax_r.burst;
    assign awid    = ax_r.id;

    // Write data comes straight from the cache, which only advances after okay.
    assign wdata   = cbus_req.wdata;
    assign wstrb   = 4'hF;
    assign wid     = AXI_ID;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cbus_req.valid) begin
                    if (cbus_req.is_write) begin
                        state_next_s = ST_AW;
                    end else begin
                        state_next_s = ST_AR;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_next_s = ST_R;
                end else begin
                    state_next_s = ST_AR;
                end
            end
            ST_R: begin
                if (rvalid && rlast) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_R;
                end
            end
            ST_AW: begin
                if (awready) begin
                    state_next_s = ST_W;
                end else begin
                    state_next_s = ST_AW;
                end
            end
            ST_W: begin
                if (wready && final_beat_s) begin
                    state_next_s = ST_B;
                end else begin
                    state_next_s = ST_W;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_B;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake and cache-response outputs, decoded from the current state
    always_comb begin
        arvalid         = 1'b0;
        awvalid         = 1'b0;
        rready          = 1'b0;
        wvalid          = 1'b0;
        wlast           = 1'b0;
        bready          = 1'b0;
        cbus_resp.okay  = 1'b0;
        cbus_resp.last  = 1'b0;
        cbus_resp.rdata = rdata;
        case (state_r)
            ST_IDLE: begin
                arvalid = 1'b0;
            end
            ST_AR: begin
                arvalid = 1'b1;
            end
            ST_R: begin
                rready         = 1'b1;
                cbus_resp.okay = rvalid;
                cbus_resp.last = rvalid & rlast;
            end
            ST_AW: begin
                awvalid = 1'b1;
            end
            ST_W: begin
                wvalid = 1'b1;
                wlast  = final_beat_s;
                // The final beat's okay is held back until B so that last
                // can mark full completion of the writeback.
                if (wready && !final_beat_s) begin
                    cbus_resp.okay = 1'b1;
                end else begin
                    cbus_resp.okay = 1'b0;
                end
            end
            ST_B: begin
                bready         = 1'b1;
                cbus_resp.okay = bvalid;
                cbus_resp.last = bvalid;
            end
            default: begin
                arvalid = 1'b0;
            end
        endcase
    end

    // Request latch at accept and write-beat counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ax_r    <= '0;
            count_r <= '0;
        end else begin
            if ((state_r == ST_IDLE) && cbus_req.valid) begin
                ax_r.addr  <= cbus_req.addr;
                ax_r.len   <= burst_info_s.len;
                ax_r.size  <= AXI_SIZE_4B;
                ax_r.burst <= burst_info_s.burst;
                ax_r.id    <= AXI_ID;
            end else begin
                ax_r <= ax_r;
            end
            if ((state_r == ST_AW) && awready) begin
                count_r <= '0;
            end else if ((state_r == ST_W) && wready) begin
                count_r <= count_r + {{(MAX_ORDER-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Directed bench for the cache-bus to AXI3 bridge. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 unit later, well clear of edges.
module tb_cbus_axi_bridge;
    import cbus_axi_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    cbus_req_t   cbus_req;
    cbus_resp_t  cbus_resp;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic [3:0]  wid;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bvalid;
    logic        bready;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cbus_axi_bridge #(.AXI_ID(4'd0), .DATA_WIDTH(32), .MAX_ORDER(4)) dut (
        .clk(clk), .resetn(resetn), .cbus_req(cbus_req), .cbus_resp(cbus_resp),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arid(arid), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid),
        .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awid(awid), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid), .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [31:0] a, input logic [2:0] o);
        cbus_req.valid    = v;
        cbus_req.is_write = w;
        cbus_req.addr     = a;
        cbus_req.order    = o;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(); cyc(); #1;
        tests_run++;
        if ({arvalid, awvalid, wvalid, rready, bready, cbus_resp.okay, cbus_resp.last} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {arvalid, awvalid, wvalid, rready, bready, cbus_resp.okay, cbus_resp.last});
        end
        resetn = 1'b1;
        cyc(); #1;
        tests_run++;
        if ({arvalid, awvalid, wvalid, rready, bready, cbus_resp.okay, cbus_resp.last} !== 7'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b want 0000000",
                     {arvalid, awvalid, wvalid, rready, bready, cbus_resp.okay, cbus_resp.last});
        end
    endtask

    task automatic test_read_order2();
        logic [31:0] exp_d;
        set_req(1'b1, 1'b0, 32'h1000_0008, 3'd2);
        #1;
        tests_run++;
        if (arvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd2_issue_latency: arvalid got %b want 0", arvalid);
        end
        // three AR cycles, arready only in the third
        for (int c = 0; c < 3; c++) begin
            cyc();
            arready = (c == 2) ? 1'b1 : 1'b0;
            #1;
            tests_run++;
            if ({arvalid, araddr, arlen, arsize, arburst, arid, rready} !==
                {1'b1, 32'h1000_0008, 4'd3, 3'b010, 2'b10, 4'd0, 1'b0}) begin
                tests_failed++;
                $display("FAIL rd2_ar_cycle%0d: got v=%b a=%h len=%0d size=%0d burst=%0d id=%0d rready=%b want v=1 a=10000008 len=3 size=2 burst=2 id=0 rready=0",
                         c, arvalid, araddr, arlen, arsize, arburst, arid, rready);
            end
        end
        cyc();
        arready = 1'b0;
        #1;
        tests_run++;
        if ({rready, arvalid, cbus_resp.okay} !== 3'b100) begin
            tests_failed++;
            $display("FAIL rd2_r_entry: rready/arvalid/okay got %b want 100", {rready, arvalid, cbus_resp.okay});
        end
        for (int i = 0; i < 4; i++) begin
            exp_d  = 32'hA5A5_0000 + 32'(i);
            rvalid = 1'b1;
            rlast  = (i == 3);
            rdata  = exp_d;
            #1;
            tests_run++;
            if ({cbus_resp.okay, cbus_resp.last, cbus_resp.rdata} !== {1'b1, (i == 3), exp_d}) begin
                tests_failed++;
                $display("FAIL rd2_beat%0d: okay=%b last=%b rdata=%h want okay=1 last=%b rdata=%h",
                         i, cbus_resp.okay, cbus_resp.last, cbus_resp.rdata, (i == 3), exp_d);
            end
            cyc();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        cbus_req.valid = 1'b0;
        #1;
        tests_run++;
        if ({rready, cbus_resp.okay, arvalid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rd2_done_idle: rready/okay/arvalid got %b want 000", {rready, cbus_resp.okay, arvalid});
        end
    endtask

    task automatic test_write_order2();
        logic [4:0]  pat;
        int          beat;
        logic [31:0] exp_d;
        pat  = 5'b11101;   // wready per W cycle, cycle 0 in bit 0: 1/0/1/1/1
        beat = 0;
        set_req(1'b1, 1'b1, 32'h2000_0014, 3'd2);
        cyc();
        #1;
        tests_run++;
        if ({awvalid, awaddr, awlen, awsize, awburst, awid, wvalid, arvalid} !==
            {1'b1, 32'h2000_0014, 4'd3, 3'b010, 2'b10, 4'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL wr2_aw_fields: got v=%b a=%h len=%0d size=%0d burst=%0d id=%0d wvalid=%b arvalid=%b want v=1 a=20000014 len=3 size=2 burst=2 id=0 wvalid=0 arvalid=0",
                     awvalid, awaddr, awlen, awsize, awburst, awid, wvalid, arvalid);
        end
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            exp_d = 32'hC0DE_0000 + 32'(beat);
            cbus_req.wdata = exp_d;
            wready = pat[j];
            #1;
            tests_run++;
            if ({wvalid, wlast, wstrb, wdata, wid, cbus_resp.okay, cbus_resp.last} !==
                {1'b1, (beat == 3), 4'hF, exp_d, 4'd0, (pat[j] && (beat != 3)), 1'b0}) begin
                tests_failed++;
                $display("FAIL wr2_w_cycle%0d: wvalid=%b wlast=%b strb=%h wdata=%h wid=%0d okay=%b last=%b want 1 %b f %h 0 %b 0",
                         j, wvalid, wlast, wstrb, wdata, wid, cbus_resp.okay, cbus_resp.last,
                         (beat == 3), exp_d, (pat[j] && (beat != 3)));
            end
            if (pat[j]) beat++;
            cyc();
        end
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bvalid = (i == 2);
            #1;
            tests_run++;
            if ({bready, wvalid, cbus_resp.okay, cbus_resp.last} !== {1'b1, 1'b0, (i == 2), (i == 2)}) begin
                tests_failed++;
                $display("FAIL wr2_b_cycle%0d: bready=%b wvalid=%b okay=%b last=%b want 1 0 %b %b",
                         i, bready, wvalid, cbus_resp.okay, cbus_resp.last, (i == 2), (i == 2));
            end
            cyc();
        end
        bvalid = 1'b0;
        cbus_req.valid = 1'b0;
        #1;
        tests_run++;
        if ({bready, cbus_resp.okay, awvalid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL wr2_done_idle: bready/okay/awvalid got %b want 000", {bready, cbus_resp.okay, awvalid});
        end
    endtask

    task automatic test_read_order0();
        set_req(1'b1, 1'b0, 32'h2000_0004, 3'd0);
        cyc();
        arready = 1'b1;
        #1;
        tests_run++;
        if ({arvalid, araddr, arlen, arburst} !== {1'b1, 32'h2000_0004, 4'd0, 2'b01}) begin
            tests_failed++;
            $display("FAIL rd0_ar_fields: v=%b a=%h len=%0d burst=%0d want v=1 a=20000004 len=0 burst=1",
                     arvalid, araddr, arlen, arburst);
        end
        cyc();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b1;
        rdata   = 32'h0BAD_F00D;
        #1;
        tests_run++;
        if ({cbus_resp.okay, cbus_resp.last, cbus_resp.rdata} !== {1'b1, 1'b1, 32'h0BAD_F00D}) begin
            tests_failed++;
            $display("FAIL rd0_single_beat: okay=%b last=%b rdata=%h want 1 1 0badf00d",
                     cbus_resp.okay, cbus_resp.last, cbus_resp.rdata);
        end
        cyc();
        rvalid = 1'b0;
        rlast  = 1'b0;
        cbus_req.valid = 1'b0;
        #1;
        tests_run++;
        if ({rready, arvalid, cbus_resp.okay} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rd0_done_idle: rready/arvalid/okay got %b want 000", {rready, arvalid, cbus_resp.okay});
        end
    endtask

    task automatic test_back_to_back();
        set_req(1'b1, 1'b0, 32'h3000_0000, 3'd1);
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b0;
        rdata   = 32'h1111_1111;
        cyc();
        rlast = 1'b1;
        rdata = 32'h2222_2222;
        #1;
        tests_run++;
        if ({cbus_resp.okay, cbus_resp.last} !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_read_last: okay/last got %b want 11", {cbus_resp.okay, cbus_resp.last});
        end
        cyc();
        // write request already valid in the cycle right after last
        rvalid = 1'b0;
        rlast  = 1'b0;
        set_req(1'b1, 1'b1, 32'h3000_0040, 3'd1);
        cbus_req.wdata = 32'h3333_0000;
        #1;
        tests_run++;
        if ({arvalid, awvalid, cbus_resp.okay} !== 3'b000) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap: arvalid/awvalid/okay got %b want 000", {arvalid, awvalid, cbus_resp.okay});
        end
        cyc();
        awready = 1'b1;
        #1;
        tests_run++;
        if ({awvalid, arvalid, awlen, awburst} !== {1'b1, 1'b0, 4'd1, 2'b10}) begin
            tests_failed++;
            $display("FAIL b2b_aw_issue: awvalid=%b arvalid=%b len=%0d burst=%0d want 1 0 1 2",
                     awvalid, arvalid, awlen, awburst);
        end
        cyc();
        awready = 1'b0;
        wready  = 1'b1;
        #1;
        tests_run++;
        if ({wvalid, wlast, cbus_resp.okay, awvalid} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL b2b_w_beat0: wvalid/wlast/okay/awvalid got %b want 1010",
                     {wvalid, wlast, cbus_resp.okay, awvalid});
        end
        cyc();
        #1;
        tests_run++;
        if ({wvalid, wlast, cbus_resp.okay} !== 3'b110) begin
            tests_failed++;
            $display("FAIL b2b_w_beat1: wvalid/wlast/okay got %b want 110", {wvalid, wlast, cbus_resp.okay});
        end
        cyc();
        wready = 1'b0;
        bvalid = 1'b1;
        #1;
        tests_run++;
        if ({bready, cbus_resp.okay, cbus_resp.last} !== 3'b111) begin
            tests_failed++;
            $display("FAIL b2b_b_done: bready/okay/last got %b want 111", {bready, cbus_resp.okay, cbus_resp.last});
        end
        cyc();
        bvalid = 1'b0;
        cbus_req.valid = 1'b0;
        #1;
        tests_run++;
        if ({arvalid, awvalid, bready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL b2b_no_reissue: arvalid/awvalid/bready got %b want 000", {arvalid, awvalid, bready});
        end
    endtask

    task automatic test_reset_mid_burst();
        set_req(1'b1, 1'b0, 32'h4000_000C, 3'd2);
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b0;
        rdata   = 32'h4444_0001;
        #1;
        tests_run++;
        if (cbus_resp.okay !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_beat0: okay got %b want 1", cbus_resp.okay);
        end
        cyc();
        rvalid = 1'b0;
        cbus_req.valid = 1'b0;
        resetn = 1'b0;
        cyc();
        rvalid = 1'b1;
        #1;
        tests_run++;
        if ({rready, cbus_resp.okay, cbus_resp.last, arvalid, awvalid} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL rst_mid_abandon: rready/okay/last/arvalid/awvalid got %b want 00000",
                     {rready, cbus_resp.okay, cbus_resp.last, arvalid, awvalid});
        end
        rvalid = 1'b0;
        resetn = 1'b1;
        set_req(1'b1, 1'b0, 32'h5000_0000, 3'd0);
        cyc();
        arready = 1'b1;
        #1;
        tests_run++;
        if ({arvalid, araddr, arlen, arburst} !== {1'b1, 32'h5000_0000, 4'd0, 2'b01}) begin
            tests_failed++;
            $display("FAIL rst_mid_fresh_ar: v=%b a=%h len=%0d burst=%0d want v=1 a=50000000 len=0 burst=1",
                     arvalid, araddr, arlen, arburst);
        end
        cyc();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b1;
        rdata   = 32'h5555_5555;
        #1;
        tests_run++;
        if ({cbus_resp.okay, cbus_resp.last, cbus_resp.rdata} !== {1'b1, 1'b1, 32'h5555_5555}) begin
            tests_failed++;
            $display("FAIL rst_mid_fresh_beat: okay=%b last=%b rdata=%h want 1 1 55555555",
                     cbus_resp.okay, cbus_resp.last, cbus_resp.rdata);
        end
        cyc();
        rvalid = 1'b0;
        rlast  = 1'b0;
        cbus_req.valid = 1'b0;
    endtask

    task automatic test_rvalid_stall();
        int   n_okay;
        logic rv;
        n_okay = 0;
        set_req(1'b1, 1'b0, 32'h6000_0004, 3'd2);
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        // beat 0, five stall cycles, then beats 1..3
        for (int c = 0; c < 9; c++) begin
            rv     = (c == 0) || (c >= 6);
            rvalid = rv;
            rlast  = (c == 8);
            rdata  = 32'h6666_0000 + 32'(c);
            #1;
            tests_run++;
            if ({cbus_resp.okay, cbus_resp.last} !== {rv, (c == 8)}) begin
                tests_failed++;
                $display("FAIL stall_cycle%0d: okay=%b last=%b want %b %b",
                         c, cbus_resp.okay, cbus_resp.last, rv, (c == 8));
            end
            if (cbus_resp.okay === 1'b1) n_okay++;
            cyc();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        cbus_req.valid = 1'b0;
        tests_run++;
        if (n_okay !== 4) begin
            tests_failed++;
            $display("FAIL stall_okay_count: got %0d want 4", n_okay);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        cbus_req = '0;
        arready  = 1'b0;
        rdata    = 32'd0;
        rresp    = 2'b00;
        rlast    = 1'b0;
        rid      = 4'd0;
        rvalid   = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        bresp    = 2'b00;
        bid      = 4'd0;
        bvalid   = 1'b0;
        test_reset();
        test_read_order2();
        test_write_order2();
        test_read_order0();
        test_back_to_back();
        test_reset_mid_burst();
        test_rvalid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", tests_failed);
        $fatal(1);
    end

endmodule
